// File: rtl/generator_pkg.sv
// Shared types and helpers for the generator collector: FSM encoding, counter width, pair layout.
package generator_pkg;

  localparam int COUNT_W    = 16;
  localparam int PAIR_WIDTH = 32;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_START   = 3'd1;
  localparam logic [2:0] S_SKIP    = 3'd2;
  localparam logic [2:0] S_COLLECT = 3'd3;
  localparam logic [2:0] S_FINISH  = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE    = S_IDLE,
    ST_START   = S_START,
    ST_SKIP    = S_SKIP,
    ST_COLLECT = S_COLLECT,
    ST_FINISH  = S_FINISH
  } collector_state_t;

  typedef struct packed {
    logic signed [PAIR_WIDTH-1:0] x;
    logic signed [PAIR_WIDTH-1:0] y;
  } pair_t;

  function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/pair_fifo.sv
// Synchronous pair FIFO with a registered head word; a push into an empty FIFO
// is visible on the head right after the pushing edge.
module pair_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               push_i,
  input  logic [2*WIDTH-1:0] data_i,
  input  logic               pop_i,
  output logic [2*WIDTH-1:0] data_o,
  output logic               full_o,
  output logic               empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [2*WIDTH-1:0] mem [DEPTH];
  logic [2*WIDTH-1:0] head_q;
  logic [AW:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic               push_ok, pop_ok;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign pop_ok  = pop_i && !empty_o;
  // A pop in the same cycle frees the slot a full-FIFO push needs.
  assign push_ok = push_i && (!full_o || pop_ok);

  assign wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, push_ok};
  assign rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, pop_ok};

  always_ff @(posedge clk_i) begin
    if (push_ok) begin
      mem[wr_ptr_q[AW-1:0]] <= data_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      head_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      // Bypass when the new head is the word being written this edge.
      if (wr_ptr_d != rd_ptr_d) begin
        head_q <= (push_ok && (rd_ptr_d == wr_ptr_q)) ? data_i : mem[rd_ptr_d[AW-1:0]];
      end
    end
  end

  assign data_o = head_q;

endmodule

// File: rtl/generator_collector.sv
// Starts a generator, captures its (out0, out1) pairs while done is low and
// buffers them for a valid/ready consumer, with drop and timeout tracking.
module generator_collector
  import generator_pkg::*;
#(
  parameter int WIDTH   = PAIR_WIDTH,
  parameter int DEPTH   = 16,
  parameter int TIMEOUT = 1024
) (
  input  logic                     _clock,
  input  logic                     _reset_n,
  input  logic                     _start,
  output logic                     _busy,
  output logic                     gen_start,
  input  logic signed [WIDTH-1:0]  gen_out0,
  input  logic signed [WIDTH-1:0]  gen_out1,
  input  logic                     gen_done,
  output logic signed [WIDTH-1:0]  _out0,
  output logic signed [WIDTH-1:0]  _out1,
  output logic                     _valid,
  input  logic                     _ready,
  output logic [COUNT_W-1:0]       _count,
  output logic                     _overflow,
  output logic                     _timeout,
  output logic                     _done
);

  localparam int TW = $clog2(TIMEOUT + 1);

  collector_state_t   state_q, state_d;
  logic [COUNT_W-1:0] count_q, count_d;
  logic [TW-1:0]      timer_q, timer_d;
  logic               overflow_q, overflow_d;
  logic               timeout_q, timeout_d;
  logic               gen_start_q, done_q, done_d;
  logic               push, pop, fifo_full, fifo_empty;
  logic [2*WIDTH-1:0] head;

  assign pop = _ready && !fifo_empty;

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    timer_d    = timer_q;
    overflow_d = overflow_q;
    timeout_d  = timeout_q;
    push       = 1'b0;
    case (state_q)
      ST_IDLE, ST_FINISH: begin
        if (_start) begin
          state_d    = ST_START;
          count_d    = '0;
          overflow_d = 1'b0;
          timeout_d  = 1'b0;
        end
      end
      ST_START: state_d = ST_SKIP;
      ST_SKIP: begin
        state_d = ST_COLLECT;
        timer_d = '0;
      end
      ST_COLLECT: begin
        if (gen_done) begin
          state_d = ST_FINISH;
        end else begin
          push    = 1'b1;
          count_d = sat_inc(count_q);
          if (fifo_full && !pop) begin
            overflow_d = 1'b1;
          end
          // The pair on the expiring cycle is still captured.
          if (timer_q == TW'(TIMEOUT - 1)) begin
            timeout_d = 1'b1;
            state_d   = ST_FINISH;
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign done_d = (state_q == ST_FINISH) && (state_d == ST_FINISH) && fifo_empty;

  always_ff @(posedge _clock or negedge _reset_n) begin
    if (!_reset_n) begin
      state_q     <= ST_IDLE;
      count_q     <= '0;
      timer_q     <= '0;
      overflow_q  <= 1'b0;
      timeout_q   <= 1'b0;
      gen_start_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      timer_q     <= timer_d;
      overflow_q  <= overflow_d;
      timeout_q   <= timeout_d;
      gen_start_q <= (state_d == ST_START);
      done_q      <= done_d;
    end
  end

  pair_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (_clock),
    .rst_ni  (_reset_n),
    .push_i  (push),
    .data_i  ({gen_out0, gen_out1}),
    .pop_i   (pop),
    .data_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign _busy     = (state_q == ST_START) || (state_q == ST_SKIP) || (state_q == ST_COLLECT);
  assign gen_start = gen_start_q;
  assign _out0     = head[2*WIDTH-1:WIDTH];
  assign _out1     = head[WIDTH-1:0];
  assign _valid    = !fifo_empty;
  assign _count    = count_q;
  assign _overflow = overflow_q;
  assign _timeout  = timeout_q;
  assign _done     = done_q;

endmodule

// File: tb/tb_generator_collector.sv
// Bench for generator_collector: a behavioural generator, a cycle table for the
// basic run, queue-model checks for random backpressure, timeout and mid-run reset.
module tb_generator_collector;
  import generator_pkg::*;

  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic rst_n;
  logic start_a, ready_a, start_b, ready_b;
  logic signed [31:0] g_out0, g_out1;
  logic g_done;

  logic a_busy, a_gs, a_valid, a_ovf, a_to, a_done;
  logic signed [31:0] a_out0, a_out1;
  logic [15:0] a_count;
  logic b_busy, b_gs, b_valid, b_ovf, b_to, b_done;
  logic signed [31:0] b_out0, b_out1;
  logic [15:0] b_count;

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  generator_collector #(.WIDTH(32), .DEPTH(DEPTH), .TIMEOUT(1024)) dut (
    ._clock(clk), ._reset_n(rst_n), ._start(start_a), ._busy(a_busy), .gen_start(a_gs),
    .gen_out0(g_out0), .gen_out1(g_out1), .gen_done(g_done),
    ._out0(a_out0), ._out1(a_out1), ._valid(a_valid), ._ready(ready_a),
    ._count(a_count), ._overflow(a_ovf), ._timeout(a_to), ._done(a_done));

  generator_collector #(.WIDTH(32), .DEPTH(DEPTH), .TIMEOUT(8)) dut_to (
    ._clock(clk), ._reset_n(rst_n), ._start(start_b), ._busy(b_busy), .gen_start(b_gs),
    .gen_out0(g_out0), .gen_out1(g_out1), .gen_done(g_done),
    ._out0(b_out0), ._out1(b_out1), ._valid(b_valid), ._ready(ready_b),
    ._count(b_count), ._overflow(b_ovf), ._timeout(b_to), ._done(b_done));

  // Behavioural generator: samples start, one stale cycle, then N pairs, then done.
  int gen_n = 0;
  int gen_step = 0;
  bit gen_active = 1'b0;
  logic signed [31:0] px [128];
  logic signed [31:0] py [128];
  initial begin
    g_done = 1'b0;
    g_out0 = '0;
    g_out1 = '0;
  end
  always @(posedge clk) begin
    if (a_gs || b_gs) begin
      gen_active <= 1'b1;
      gen_step   <= 0;
    end else if (gen_active) begin
      if (gen_step < gen_n) begin
        g_out0 <= px[gen_step];
        g_out1 <= py[gen_step];
        g_done <= 1'b0;
      end else begin
        g_done     <= 1'b1;
        gen_active <= 1'b0;
      end
      gen_step <= gen_step + 1;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference queue model
  pair_t q[$];
  int m_cnt;
  bit m_ovf;

  function automatic bit ready_for(input int mode, input int e, input int n);
    if (e > n + 6) return 1'b1;
    case (mode)
      0: return 1'b0;
      1: return 1'b1;
      2: return ($urandom_range(0, 3) == 0);
      default: return (e == 19);
    endcase
  endfunction

  task automatic run_gen(input int n, input int mode, output int pops);
    bit rdy;
    int sz_before;
    pair_t p;
    gen_n = n;
    pops = 0;
    for (int e = 0; e <= n + 9 + DEPTH; e++) begin
      rdy = ready_for(mode, e, n);
      start_a = (e == 0);
      ready_a = rdy;
      tick();
      start_a = 1'b0;
      sz_before = q.size();
      if (e == 0) begin
        m_cnt = 0;
        m_ovf = 1'b0;
      end
      if (rdy && q.size() > 0) begin
        void'(q.pop_front());
        pops++;
      end
      if (e >= 3 && e <= n + 2) begin
        if (m_cnt < 65535) m_cnt++;
        p.x = px[e-3];
        p.y = py[e-3];
        if (q.size() < DEPTH) q.push_back(p);
        else m_ovf = 1'b1;
      end
      check("gen_start", 64'(a_gs), 64'(e == 0));
      check("busy", 64'(a_busy), 64'(e <= n + 2));
      check("valid", 64'(a_valid), 64'(q.size() > 0));
      if (q.size() > 0) check("head", {a_out0, a_out1}, q[0]);
      check("count", 64'(a_count), 64'(m_cnt));
      check("overflow", 64'(a_ovf), 64'(m_ovf));
      check("timeout", 64'(a_to), 64'(0));
      check("done", 64'(a_done), 64'((e >= n + 4) && (sz_before == 0)));
    end
    ready_a = 1'b0;
    $display("run n=%0d mode=%0d count=%0d overflow=%0b pops=%0d", n, mode, a_count, a_ovf, pops);
  endtask

  typedef struct {
    bit start; bit ready;
    bit gs; bit busy; bit valid; int o0; int o1; int cnt; bit done;
  } vec_t;
  vec_t tbl[8];

  initial begin
    int pops;
    int cnt_exp;
    rst_n = 1'b0;
    start_a = 1'b0; ready_a = 1'b0; start_b = 1'b0; ready_b = 1'b0;
    repeat (3) tick();
    check("rst_busy", 64'(a_busy), 64'(0));
    check("rst_gen_start", 64'(a_gs), 64'(0));
    check("rst_valid", 64'(a_valid), 64'(0));
    check("rst_done", 64'(a_done), 64'(0));
    check("rst_flags", 64'({a_ovf, a_to}), 64'(0));
    check("rst_count", 64'(a_count), 64'(0));
    check("rst_out", {a_out0, a_out1}, 64'(0));
    rst_n = 1'b1;
    tick();

    // Two-pair run with ready held high; row i is sampled after edge Ei.
    tbl[0] = '{1, 1, 1, 1, 0, 0, 0, 0, 0};
    tbl[1] = '{0, 1, 0, 1, 0, 0, 0, 0, 0};
    tbl[2] = '{1, 1, 0, 1, 0, 0, 0, 0, 0};
    tbl[3] = '{0, 1, 0, 1, 1, 1, 2, 1, 0};
    tbl[4] = '{0, 1, 0, 1, 1, 3, 4, 2, 0};
    tbl[5] = '{0, 1, 0, 0, 0, 0, 0, 2, 0};
    tbl[6] = '{0, 1, 0, 0, 0, 0, 0, 2, 1};
    tbl[7] = '{0, 1, 0, 0, 0, 0, 0, 2, 1};
    px[0] = 1; py[0] = 2; px[1] = 3; py[1] = 4;
    gen_n = 2;
    for (int i = 0; i < 8; i++) begin
      start_a = tbl[i].start;
      ready_a = tbl[i].ready;
      tick();
      start_a = 1'b0;
      check("tbl_gen_start", 64'(a_gs), 64'(tbl[i].gs));
      check("tbl_busy", 64'(a_busy), 64'(tbl[i].busy));
      check("tbl_valid", 64'(a_valid), 64'(tbl[i].valid));
      if (tbl[i].valid) begin
        check("tbl_out0", 64'(a_out0), 64'(tbl[i].o0));
        check("tbl_out1", 64'(a_out1), 64'(tbl[i].o1));
      end
      check("tbl_count", 64'(a_count), 64'(tbl[i].cnt));
      check("tbl_done", 64'(a_done), 64'(tbl[i].done));
      check("tbl_overflow", 64'(a_ovf), 64'(0));
    end
    $display("table run complete");
    ready_a = 1'b0;

    // Same pairs held under backpressure, released later.
    run_gen(2, 0, pops);
    check("bp_count", 64'(a_count), 64'(2));
    check("bp_pops", 64'(pops), 64'(2));

    // Twenty pairs into sixteen slots.
    for (int i = 0; i < 20; i++) begin
      px[i] = $signed($urandom);
      py[i] = $signed($urandom);
    end
    run_gen(20, 0, pops);
    check("ovf_count", 64'(a_count), 64'(20));
    check("ovf_flag", 64'(a_ovf), 64'(1));
    check("ovf_pops", 64'(pops), 64'(16));

    // Full FIFO with a pop alongside the next push.
    run_gen(17, 3, pops);
    check("fullpop_flag", 64'(a_ovf), 64'(0));
    check("fullpop_count", 64'(a_count), 64'(17));
    check("fullpop_pops", 64'(pops), 64'(17));

    // Random pairs under random backpressure.
    for (int r = 0; r < 6; r++) begin
      int n;
      n = $urandom_range(1, 40);
      for (int i = 0; i < n; i++) begin
        px[i] = $signed($urandom);
        py[i] = $signed($urandom);
      end
      run_gen(n, (r == 0) ? 1 : 2, pops);
    end

    // Timeout: generator never finishes within 8 collect cycles.
    for (int i = 0; i < 100; i++) begin
      px[i] = $signed($urandom);
      py[i] = $signed($urandom);
    end
    gen_n = 100;
    for (int e = 0; e <= 12; e++) begin
      start_b = (e == 0);
      tick();
      start_b = 1'b0;
      cnt_exp = (e < 3) ? 0 : ((e - 2 < 8) ? e - 2 : 8);
      check("to_flag", 64'(b_to), 64'(e >= 10));
      check("to_busy", 64'(b_busy), 64'(e <= 9));
      check("to_count", 64'(b_count), 64'(cnt_exp));
    end
    check("to_valid", 64'(b_valid), 64'(1));
    check("to_done_pending", 64'(b_done), 64'(0));
    ready_b = 1'b1;
    for (int k = 0; k < 8; k++) begin
      check("to_drain_head", {b_out0, b_out1}, {px[k], py[k]});
      tick();
    end
    tick();
    check("to_done", 64'(b_done), 64'(1));
    check("to_empty", 64'(b_valid), 64'(0));
    ready_b = 1'b0;
    $display("timeout run count=%0d timeout=%0b", b_count, b_to);

    // Reset during COLLECT after one pair.
    for (int i = 0; i < 5; i++) begin
      px[i] = $signed($urandom);
      py[i] = $signed($urandom);
    end
    gen_n = 5;
    for (int e = 0; e <= 3; e++) begin
      start_a = (e == 0);
      tick();
      start_a = 1'b0;
    end
    check("pre_rst_valid", 64'(a_valid), 64'(1));
    check("pre_rst_count", 64'(a_count), 64'(1));
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 64'(a_valid), 64'(0));
    check("mid_rst_count", 64'(a_count), 64'(0));
    check("mid_rst_out", {a_out0, a_out1}, 64'(0));
    check("mid_rst_ctl", 64'({a_busy, a_gs, a_done, a_ovf, a_to}), 64'(0));
    tick();
    rst_n = 1'b1;
    q.delete();
    run_gen(3, 1, pops);
    check("post_rst_count", 64'(a_count), 64'(3));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
